// File: rtl/viterbi_core_param_if.sv
// Symbol-in / decoded-bit-out bundle for the parametrised Viterbi core.
// The core sits on the slave side; the symbol source/sink is the master.
interface viterbi_core_param_if #(
    parameter int SOFT_W = 3
) ();
    logic              in_valid_i;
    logic              in_ready_o;
    logic              in_sop_i;
    logic              in_eop_i;
    logic [SOFT_W-1:0] sym0_i;
    logic [SOFT_W-1:0] sym1_i;
    logic              out_data_o;
    logic              out_valid_o;
    logic              out_last_o;

    modport master (
        output in_valid_i, in_sop_i, in_eop_i, sym0_i, sym1_i,
        input  in_ready_o, out_data_o, out_valid_o, out_last_o
    );

    modport slave (
        input  in_valid_i, in_sop_i, in_eop_i, sym0_i, sym1_i,
        output in_ready_o, out_data_o, out_valid_o, out_last_o
    );
endinterface

// File: rtl/viterbi_core_param.sv
// Soft-decision rate-1/2 Viterbi decoder: per-state ACS in a generate loop,
// register-exchange survivors, min-subtract metric normalisation and a
// RUN/DRAIN FSM that flushes the state-0 survivor at end of frame.
module viterbi_core_param #(
    parameter int K        = 3,
    parameter int G0       = 7,
    parameter int G1       = 5,
    parameter int SOFT_W   = 3,
    parameter int TB_DEPTH = 15,
    parameter int METRIC_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    viterbi_core_param_if.slave   bus
);
    localparam int N  = 1 << (K - 1);
    localparam int S  = K - 1;
    localparam int D  = TB_DEPTH;
    localparam int BW = SOFT_W + 1;
    localparam int CW = $clog2(TB_DEPTH + 1);

    localparam logic [K-1:0]        G0V     = K'(G0);
    localparam logic [K-1:0]        G1V     = K'(G1);
    localparam logic [SOFT_W-1:0]   SYM_MAX = '1;
    localparam logic [METRIC_W-1:0] PM_MAX  = '1;
    localparam logic [METRIC_W-1:0] PM_INIT = METRIC_W'(1) << (METRIC_W - 2);
    localparam logic [CW-1:0]       D_C     = CW'(D);
    localparam logic [CW-1:0]       DM1_C   = CW'(D - 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                      state;
    logic [N-1:0][METRIC_W-1:0]  pm, pm_use, pm_new, pm_norm;
    logic [N-1:0][D-2:0]         surv, surv_use;
    logic [N-1:0][D-1:0]         surv_new;
    logic [D-2:0]                surv0_lat;
    logic [CW-1:0]               cnt, cnt_base, cnt_after, drain_len, drain_idx;
    logic [METRIC_W-1:0]         pm_min;
    logic [S-1:0]                best;
    logic                        ready, accept;
    logic                        out_data, out_valid, out_last;

    assign accept          = bus.in_valid_i & ready;
    assign bus.in_ready_o  = ready;
    assign bus.out_data_o  = out_data;
    assign bus.out_valid_o = out_valid;
    assign bus.out_last_o  = out_last;

    // Cost of one branch: distance of both soft symbols from the expected coded bits.
    function automatic logic [BW-1:0] branch_metric(input logic [S-1:0] p, input logic b,
                                                    input logic [SOFT_W-1:0] y0,
                                                    input logic [SOFT_W-1:0] y1);
        logic [K-1:0]      r;
        logic [SOFT_W-1:0] k0, k1;
        r  = {b, p};
        k0 = (^(G0V & r)) ? SYM_MAX - y0 : y0;
        k1 = (^(G1V & r)) ? SYM_MAX - y1 : y1;
        return {1'b0, k0} + {1'b0, k1};
    endfunction

    // A sop symbol starts from the init metrics, empty survivors and a fresh count.
    always_comb begin
        pm_use = pm;
        if (bus.in_sop_i) begin
            pm_use    = {N{PM_INIT}};
            pm_use[0] = '0;
        end
        surv_use  = bus.in_sop_i ? '0 : surv;
        cnt_base  = bus.in_sop_i ? '0 : cnt;
        cnt_after = (cnt_base >= D_C) ? D_C : cnt_base + CW'(1);
        drain_len = (cnt_after < D_C) ? cnt_after : DM1_C;
    end

    // Add-compare-select per next state; ties go to the x=0 predecessor.
    for (genvar g = 0; g < N; g++) begin : g_acs
        localparam logic [S-1:0] NS = S'(g);
        localparam logic [S-1:0] P0 = {NS[S-2:0], 1'b0};
        localparam logic [S-1:0] P1 = {NS[S-2:0], 1'b1};
        logic [METRIC_W:0]   sum0, sum1;
        logic [METRIC_W-1:0] cand0, cand1;
        logic                take1;
        assign sum0  = {1'b0, pm_use[P0]} +
                       (METRIC_W+1)'(branch_metric(P0, NS[S-1], bus.sym0_i, bus.sym1_i));
        assign sum1  = {1'b0, pm_use[P1]} +
                       (METRIC_W+1)'(branch_metric(P1, NS[S-1], bus.sym0_i, bus.sym1_i));
        assign cand0 = sum0[METRIC_W] ? PM_MAX : sum0[METRIC_W-1:0];
        assign cand1 = sum1[METRIC_W] ? PM_MAX : sum1[METRIC_W-1:0];
        assign take1 = cand1 < cand0;
        assign pm_new[g]   = take1 ? cand1 : cand0;
        assign surv_new[g] = {(take1 ? surv_use[P1] : surv_use[P0]), NS[S-1]};
    end

    // Minimum new metric (lowest index wins ties) picks the output path and normalises.
    always_comb begin
        pm_min = pm_new[0];
        best   = '0;
        for (int i = 1; i < N; i++) begin
            if (pm_new[i] < pm_min) begin
                pm_min = pm_new[i];
                best   = S'(i);
            end
        end
        for (int i = 0; i < N; i++) pm_norm[i] = pm_new[i] - pm_min;
    end

    // RUN/DRAIN control, trellis state update and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ready     <= 1'b0;
            pm        <= {N{PM_INIT}} & ~{{(N-1)*METRIC_W{1'b0}}, {METRIC_W{1'b1}}};
            surv      <= '0;
            surv0_lat <= '0;
            cnt       <= '0;
            drain_idx <= '0;
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                RUN: begin
                    ready <= 1'b1;
                    if (accept) begin
                        pm  <= pm_norm;
                        cnt <= cnt_after;
                        for (int i = 0; i < N; i++) surv[i] <= surv_new[i][D-2:0];
                        if (bus.in_eop_i) begin
                            // Zero tail forces the frame to end in state 0.
                            if (cnt_after >= D_C) begin
                                out_valid <= 1'b1;
                                out_data  <= surv_new[0][D-1];
                            end
                            surv0_lat <= surv_new[0][D-2:0];
                            drain_idx <= drain_len - CW'(1);
                            ready     <= 1'b0;
                            state     <= DRAIN;
                        end else if (cnt_after >= D_C) begin
                            out_valid <= 1'b1;
                            out_data  <= surv_new[best][D-1];
                        end
                    end
                end
                DRAIN: begin
                    out_valid <= 1'b1;
                    out_data  <= surv0_lat[drain_idx];
                    if (drain_idx == '0) begin
                        out_last <= 1'b1;
                        ready    <= 1'b1;
                        state    <= RUN;
                    end else begin
                        drain_idx <= drain_idx - CW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
